// File: rtl/tick_gen_per_if.sv
// Peripheral bus bundle for tick_gen_per (MSP430-style word-addressed bus).
//
// Bus protocol: single-cycle, no valid/ready handshake. A cycle is active when
// per_en=1. per_we!=0 is a write, and each byte lane is written only when its
// per_we bit is set. per_we==0 is a read, and the addressed slave drives
// per_dout combinationally in the same cycle. Slaves drive per_dout to zero
// when they are not addressed, so the master can OR all slave outputs together.
interface tick_gen_per_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (output per_addr, output per_din, output per_en, output per_we,
                    input  per_dout);
    modport slave  (input  per_addr, input  per_din, input  per_en, input  per_we,
                    output per_dout);
endinterface

// File: rtl/tick_gen_per.sv
// Programmable tick generator. Divides mclk by (reload+1), emits a one-cycle
// tick and raises a pending interrupt on each tick. Six word registers sit at
// BASE_ADDR..BASE_ADDR+5.
module tick_gen_per #(
    parameter logic [13:0] BASE_ADDR    = 14'h090,
    parameter logic [27:0] RESET_RELOAD = 28'h2FAF07F
) (
    input  logic           mclk,
    input  logic           puc_rst_n,
    tick_gen_per_if.slave  bus,
    output logic           tick,
    output logic           irq,
    input  logic           irqacc
);

    logic        r_en;
    logic        r_ie;
    logic        r_oneshot;
    logic [27:0] r_reload;
    logic [27:0] r_cnt;
    logic        r_pend;
    logic        r_ovr;
    logic [11:0] r_cnt_hi_snap;

    logic [13:0] w_off;
    logic        w_hit;
    logic [2:0]  w_reg;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_ctrl;
    logic        w_en_rise;
    logic        w_tick;
    logic        w_set_pend;
    logic        w_set_ovr;
    logic        w_clr_pend;
    logic        w_clr_ovr;

    // Address decode: unsigned subtraction makes addresses below the base wrap
    // to large offsets, so a single compare covers both ends of the window.
    assign w_off = bus.per_addr - BASE_ADDR;
    assign w_hit = (w_off < 14'd6);
    assign w_reg = w_off[2:0];
    assign w_wr  = bus.per_en & (|bus.per_we) & w_hit;
    assign w_rd  = bus.per_en & (bus.per_we == 2'b00) & w_hit;

    // All CTRL bits live in the low byte, so only lane 0 can change CTRL.
    assign w_wr_ctrl = w_wr & (w_reg == 3'd0) & bus.per_we[0];
    assign w_en_rise = w_wr_ctrl & bus.per_din[0] & ~r_en;

    assign w_tick = r_en & (r_cnt == 28'd0);

    // Interrupt flags: set has priority over any clear in the same cycle.
    assign w_set_pend = w_tick & r_ie;
    assign w_set_ovr  = w_tick & r_ie & r_pend;
    assign w_clr_pend = irqacc |
                        (w_wr & (w_reg == 3'd3) & bus.per_we[0] & bus.per_din[0]);
    assign w_clr_ovr  = w_wr & (w_reg == 3'd3) & bus.per_we[0] & bus.per_din[1];

    // CTRL register: a bus write beats the one-shot auto-clear of EN.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_en      <= 1'b0;
            r_ie      <= 1'b0;
            r_oneshot <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en      <= bus.per_din[0];
            r_ie      <= bus.per_din[1];
            r_oneshot <= bus.per_din[2];
        end else if (w_tick & r_oneshot) begin
            r_en      <= 1'b0;
        end
    end

    // Reload register, byte-lane writable; never touches the live counter.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_reload <= RESET_RELOAD;
        end else if (w_wr) begin
            if (w_reg == 3'd1) begin
                if (bus.per_we[0]) r_reload[7:0]   <= bus.per_din[7:0];
                if (bus.per_we[1]) r_reload[15:8]  <= bus.per_din[15:8];
            end else if (w_reg == 3'd2) begin
                if (bus.per_we[0]) r_reload[23:16] <= bus.per_din[7:0];
                if (bus.per_we[1]) r_reload[27:24] <= bus.per_din[11:8];
            end
        end
    end

    // Down-counter: restart on EN 0->1, reload after reaching zero, hold when off.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_cnt <= RESET_RELOAD;
        end else if (w_en_rise) begin
            r_cnt <= r_reload;
        end else if (r_en) begin
            r_cnt <= (r_cnt == 28'd0) ? r_reload : (r_cnt - 28'd1);
        end
    end

    // Pending / overrun flags (overrun is sticky until written with 1).
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_pend <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_pend <= w_set_pend | (r_pend & ~w_clr_pend);
            r_ovr  <= w_set_ovr  | (r_ovr  & ~w_clr_ovr);
        end
    end

    // Reading COUNT_LO captures the upper count bits for a coherent COUNT_HI read.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            r_cnt_hi_snap <= 12'h000;
        end else if (w_rd & (w_reg == 3'd4)) begin
            r_cnt_hi_snap <= r_cnt[27:16];
        end
    end

    // Read mux: zero unless this block is addressed by a read.
    always_comb begin
        bus.per_dout = 16'h0000;
        if (w_rd) begin
            case (w_reg)
                3'd0:    bus.per_dout = {13'd0, r_oneshot, r_ie, r_en};
                3'd1:    bus.per_dout = r_reload[15:0];
                3'd2:    bus.per_dout = {4'd0, r_reload[27:16]};
                3'd3:    bus.per_dout = {14'd0, r_ovr, r_pend};
                3'd4:    bus.per_dout = r_cnt[15:0];
                3'd5:    bus.per_dout = {4'd0, r_cnt_hi_snap};
                default: bus.per_dout = 16'h0000;
            endcase
        end
    end

    assign tick = w_tick;
    assign irq  = r_pend;

endmodule
